// File: rtl/nonogram_line_solver.sv
// nonogram_line_solver
//   Line-at-a-time nonogram constraint engine. A header names a line (rows
//   first, then columns) and how many candidate options follow. Each option
//   is checked against the current board knowledge. The block returns a
//   keep/discard verdict for it, and the consistent ones are folded into
//   AND/OR accumulators. At end of line, every cell on which all kept options
//   agree becomes known. At end of pass, the block reports solved, stalled or
//   continues.
// Ports:
//   clk, rst              clock, async active-high reset
//   start                 clear board/flags, latch num_rows/num_cols, enter S_HDR
//   hdr_valid/ready       header handshake (hdr_line, hdr_count)
//   opt_valid/ready       option handshake (option, bit i = cell i of the line)
//   keep_valid/keep       registered verdict, one per accepted option
//   known/assigned        board knowledge, row-major with stride MAX_DIM
//   pass_done             pulse after the last line of a pass commits
//   options_remaining     kept options in the last completed pass (saturating)
//   solved/unsolvable/stalled  sticky status until start/rst
module nonogram_line_solver #(
  parameter int MAX_DIM = 11,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 7,
  parameter int TOT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [3:0]                   num_rows,
  input  logic [3:0]                   num_cols,
  input  logic                         hdr_valid,
  output logic                         hdr_ready,
  input  logic [IDX_W-1:0]             hdr_line,
  input  logic [CNT_W-1:0]             hdr_count,
  input  logic                         opt_valid,
  output logic                         opt_ready,
  input  logic [MAX_DIM-1:0]           option,
  output logic                         keep_valid,
  output logic                         keep,
  output logic [MAX_DIM*MAX_DIM-1:0]   known,
  output logic [MAX_DIM*MAX_DIM-1:0]   assigned,
  output logic                         pass_done,
  output logic [TOT_W-1:0]             options_remaining,
  output logic                         solved,
  output logic                         unsolvable,
  output logic                         stalled
);
  localparam int CELLS = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_OPT, S_COMMIT, S_DONE} state_t;
  state_t state, state_nx;

  logic [3:0]         nrows, ncols;
  logic               is_row;
  logic [IDX_W-1:0]   sel;          // row or column number of the current line
  logic [CNT_W-1:0]   cnt_left, kept;
  logic [MAX_DIM-1:0] and_acc, or_acc;
  logic [TOT_W-1:0]   total;
  logic [IDX_W:0]     lines_done;
  logic               changed;

  logic               hdr_fire, opt_fire, hdr_legal, hdr_is_row;
  logic [IDX_W:0]     line_total;
  logic [3:0]         line_len;
  logic [MAX_DIM-1:0] lmask, line_known, line_asg, force_mask;
  logic               consistent, newly, last_line, all_known;
  logic [CELLS-1:0]   known_nx, assigned_nx;
  logic [TOT_W:0]     total_sum;
  logic [TOT_W-1:0]   total_nx;

  // Board index of cell i on the current line.
  function automatic int cell_idx(input logic row, input logic [IDX_W-1:0] s, input int i);
    return row ? int'(s) * MAX_DIM + i : i * MAX_DIM + int'(s);
  endfunction

  assign hdr_ready  = (state == S_HDR);
  assign opt_ready  = (state == S_OPT);
  assign hdr_fire   = hdr_valid & hdr_ready & ~start;
  assign opt_fire   = opt_valid & opt_ready & ~start;
  assign line_total = (IDX_W+1)'(nrows) + (IDX_W+1)'(ncols);
  assign hdr_legal  = ({1'b0, hdr_line} < line_total);
  assign hdr_is_row = (hdr_line < IDX_W'(nrows));
  assign line_len   = is_row ? ncols : nrows;

  always_comb begin
    lmask = '0;
    line_known = '0;
    line_asg = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      int idx;
      idx = cell_idx(is_row, sel, i);
      lmask[i] = (int'(line_len) > i);
      if (idx < CELLS) begin
        line_known[i] = known[idx];
        line_asg[i]   = assigned[idx];
      end
    end
  end

  // An option only conflicts where the cell is already known and disagrees.
  assign consistent = ~|(line_known & lmask & (option ^ line_asg));
  // Cells on which every kept option agrees (all filled or all empty).
  assign force_mask = lmask & ~line_known & (and_acc | ~or_acc);
  assign newly      = |force_mask;
  assign last_line  = (lines_done + 1'b1 == line_total);
  assign total_sum  = {1'b0, total} + (TOT_W+1)'(kept);
  assign total_nx   = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];

  always_comb begin
    known_nx    = known;
    assigned_nx = assigned;
    for (int i = 0; i < MAX_DIM; i++) begin
      int idx;
      idx = cell_idx(is_row, sel, i);
      if (force_mask[i] && idx < CELLS) begin
        known_nx[idx]    = 1'b1;
        assigned_nx[idx] = and_acc[i];
      end
    end
  end

  always_comb begin
    all_known = 1'b1;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        if (r < int'(nrows) && c < int'(ncols) && !known_nx[r*MAX_DIM+c])
          all_known = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) state_nx = S_HDR;
    else begin
      case (state)
        S_HDR:
          if (hdr_fire)
            state_nx = (!hdr_legal || hdr_count == '0) ? S_DONE : S_OPT;
        S_OPT:
          if (opt_fire && cnt_left == CNT_W'(1)) state_nx = S_COMMIT;
        S_COMMIT:
          if (kept == '0) state_nx = S_DONE;
          else if (last_line && (all_known || !(changed || newly))) state_nx = S_DONE;
          else state_nx = S_HDR;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nrows <= '0; ncols <= '0; is_row <= 1'b0; sel <= '0;
      cnt_left <= '0; kept <= '0; and_acc <= '0; or_acc <= '0;
      total <= '0; lines_done <= '0; changed <= 1'b0;
      keep_valid <= 1'b0; keep <= 1'b0; known <= '0; assigned <= '0;
      pass_done <= 1'b0; options_remaining <= '0;
      solved <= 1'b0; unsolvable <= 1'b0; stalled <= 1'b0;
    end else begin
      keep_valid <= 1'b0;
      pass_done  <= 1'b0;
      if (start) begin
        nrows <= num_rows; ncols <= num_cols;
        known <= '0; assigned <= '0;
        total <= '0; lines_done <= '0; changed <= 1'b0;
        kept <= '0; and_acc <= '0; or_acc <= '0;
        options_remaining <= '0;
        solved <= 1'b0; unsolvable <= 1'b0; stalled <= 1'b0;
      end else begin
        case (state)
          S_HDR: if (hdr_fire) begin
            is_row   <= hdr_is_row;
            sel      <= hdr_is_row ? hdr_line : hdr_line - IDX_W'(nrows);
            cnt_left <= hdr_count;
            and_acc  <= '1;
            or_acc   <= '0;
            kept     <= '0;
            if (!hdr_legal || hdr_count == '0) unsolvable <= 1'b1;
          end
          S_OPT: if (opt_fire) begin
            keep_valid <= 1'b1;
            keep       <= consistent;
            cnt_left   <= cnt_left - 1'b1;
            if (consistent) begin
              and_acc <= and_acc & option;
              or_acc  <= or_acc | option;
              kept    <= kept + 1'b1;
            end
          end
          S_COMMIT: begin
            if (kept == '0) unsolvable <= 1'b1;
            else begin
              known    <= known_nx;
              assigned <= assigned_nx;
              if (last_line) begin
                pass_done         <= 1'b1;
                options_remaining <= total_nx;
                total             <= '0;
                lines_done        <= '0;
                changed           <= 1'b0;
                if (all_known) solved <= 1'b1;
                else if (!(changed || newly)) stalled <= 1'b1;
              end else begin
                total      <= total_nx;
                lines_done <= lines_done + 1'b1;
                changed    <= changed | newly;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nonogram_line_solver.sv
module tb_nonogram_line_solver;
  localparam int MD = 11;

  logic clk = 0, rst = 1, start = 0;
  logic [3:0] num_rows = 0, num_cols = 0;
  logic hdr_valid = 0, hdr_ready;
  logic [4:0] hdr_line = 0;
  logic [6:0] hdr_count = 0;
  logic opt_valid = 0, opt_ready;
  logic [MD-1:0] option = 0;
  logic keep_valid, keep;
  logic [MD*MD-1:0] known, assigned;
  logic pass_done, solved, unsolvable, stalled;
  logic [15:0] options_remaining;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  nonogram_line_solver dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_line(hdr_line), .hdr_count(hdr_count),
    .opt_valid(opt_valid), .opt_ready(opt_ready), .option(option),
    .keep_valid(keep_valid), .keep(keep), .known(known), .assigned(assigned),
    .pass_done(pass_done), .options_remaining(options_remaining),
    .solved(solved), .unsolvable(unsolvable), .stalled(stalled)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int r, input int c);
    num_rows = 4'(r); num_cols = 4'(c);
    start = 1; step(); start = 0;
  endtask

  task automatic send_hdr(input int line, input int cnt);
    int t = 0;
    while (!hdr_ready && t < 50) begin step(); t++; end
    chk("hdr_ready_wait", hdr_ready, 1);
    hdr_line = 5'(line); hdr_count = 7'(cnt); hdr_valid = 1;
    step(); hdr_valid = 0;
  endtask

  task automatic send_opt(input string tag, input logic [MD-1:0] o, input logic exp_keep);
    int t = 0;
    while (!opt_ready && t < 50) begin step(); t++; end
    option = o; opt_valid = 1;
    step(); opt_valid = 0;
    chk({tag, "_kv"}, keep_valid, 1);
    chk({tag, "_keep"}, keep, exp_keep);
  endtask

  logic [127:0] ek, ea;

  initial begin
    // reset state
    step(); step();
    chk("rst_known", known, 0);
    chk("rst_hdr_ready", hdr_ready, 0);
    chk("rst_flags", {pass_done, solved, unsolvable, stalled, keep_valid}, 0);
    rst = 0; step();

    // reset mid-S_OPT aborts at once
    do_start(3, 3);
    chk("start_hdr_ready", hdr_ready, 1);
    send_hdr(0, 2);
    send_opt("abort_o1", 11'b010, 1);
    chk("in_opt", opt_ready, 1);
    rst = 1; #1;
    chk("rst_async_rdy", {hdr_ready, opt_ready}, 0);
    chk("rst_async_kv", keep_valid, 0);
    #2 rst = 0; step();
    chk("idle_after_rst", hdr_ready, 0);

    // 3x3 forced lines, filtering, then solved
    do_start(3, 3);
    send_hdr(2, 1); send_opt("row2", 11'b000, 1); step();
    ek = 0; ek[22] = 1; ek[23] = 1; ek[24] = 1;
    chk("row2_known", known, ek);
    chk("row2_asg", assigned, 0);
    send_hdr(3, 1); send_opt("col0", 11'b000, 1); step();
    ek[0] = 1; ek[11] = 1;
    chk("col0_known", known, ek);
    send_hdr(4, 3);
    send_opt("col1_001", 11'b001, 1);
    send_opt("col1_010", 11'b010, 1);
    send_opt("col1_100", 11'b100, 0);
    step();
    chk("col1_nochange", known, ek);
    send_hdr(0, 1); send_opt("row0", 11'b010, 1);
    send_hdr(1, 1); send_opt("row1", 11'b100, 1);
    send_hdr(5, 1); send_opt("col2", 11'b010, 1);
    step();
    ek = 0; ea = 0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ek[r*MD+c] = 1;
    ea[1] = 1; ea[13] = 1;
    chk("s3_pass_done", pass_done, 1);
    chk("s3_solved", solved, 1);
    chk("s3_stall_unsolv", {stalled, unsolvable}, 0);
    chk("s3_opt_rem", options_remaining, 7);
    chk("s3_known", known, ek);
    chk("s3_asg", assigned, ea);
    chk("s3_done_rdy", hdr_ready, 0);
    step();
    chk("s3_pd_pulse", pass_done, 0);

    // ambiguous board stalls on the second pass
    do_start(3, 3);
    chk("restart_clear", {solved, known[0]}, 0);
    for (int p = 0; p < 2; p++) begin
      send_hdr(0, 2); send_opt("amb_r0a", 11'b010, 1); send_opt("amb_r0b", 11'b100, 1);
      send_hdr(1, 2); send_opt("amb_r1a", 11'b010, 1); send_opt("amb_r1b", 11'b100, 1);
      send_hdr(2, 1); send_opt("amb_r2", 11'b000, 1);
      send_hdr(3, 1); send_opt("amb_c0", 11'b000, 1);
      send_hdr(4, 2); send_opt("amb_c1a", 11'b001, 1); send_opt("amb_c1b", 11'b010, 1);
      send_hdr(5, 2); send_opt("amb_c2a", 11'b001, 1); send_opt("amb_c2b", 11'b010, 1);
      step();
      chk("amb_pass_done", pass_done, 1);
      chk("amb_opt_rem", options_remaining, 10);
      chk("amb_solved", solved, 0);
      chk("amb_stalled", stalled, (p == 1));
      chk("amb_hdr_ready", hdr_ready, (p == 0));
    end

    // contradiction: row 0 all filled after cell 0 known empty
    do_start(3, 3);
    send_hdr(3, 1); send_opt("ctr_c0", 11'b000, 1);
    send_hdr(0, 1); send_opt("ctr_r0", 11'b111, 0);
    step();
    chk("ctr_unsolv", unsolvable, 1);
    chk("ctr_solved_pd", {solved, pass_done}, 0);
    chk("ctr_hdr_ready", hdr_ready, 0);

    // illegal line index and zero option count
    do_start(3, 3);
    chk("ill_clear", unsolvable, 0);
    send_hdr(6, 1);
    chk("ill_unsolv", unsolvable, 1);
    chk("ill_rdy", {hdr_ready, opt_ready}, 0);
    do_start(2, 2);
    send_hdr(1, 0);
    chk("cnt0_unsolv", unsolvable, 1);

    // 2x2 diagonal; row 0 option has junk above the line length
    do_start(2, 2);
    send_hdr(0, 1); send_opt("d_r0", 11'h7FD, 1);
    send_hdr(1, 1); send_opt("d_r1", 11'b10, 1);
    send_hdr(2, 1); send_opt("d_c0", 11'b01, 1);
    send_hdr(3, 1); send_opt("d_c1", 11'b10, 1);
    step();
    ek = 0; ek[0] = 1; ek[1] = 1; ek[11] = 1; ek[12] = 1;
    ea = 0; ea[0] = 1; ea[12] = 1;
    chk("d_pass_done", pass_done, 1);
    chk("d_solved", {solved, unsolvable, stalled}, 3'b100);
    chk("d_opt_rem", options_remaining, 4);
    chk("d_known", known, ek);
    chk("d_asg", assigned, ea);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
